// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: serialises words from a valid/ready stream and counts overlapping PATTERN matches.
// Optional build macro SEQ_LSB_FIRST_EN serialises each word LSB-first (default MSB-first).
module seq_stream_ctrl #(
   parameter int         DATA_W  = 8,
   parameter int         CNT_W   = 8,
   parameter logic [3:0] PATTERN = 4'b1001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [CNT_W-1:0]  i_threshold,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_bit_out,
   output logic              o_bit_vld,
   output logic              o_match,
   output logic [CNT_W-1:0]  o_match_cnt,
   output logic              o_busy,
   output logic              o_done
);

   localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HALT} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [2:0]        r_hist;
   logic [2:0]        r_fill;
   logic              r_match;
   logic [CNT_W-1:0]  r_match_cnt;

   logic              w_serial_bit;
   logic [DATA_W-1:0] w_shreg_next;
   logic              w_normal;
   logic              w_accept;
   logic              w_shift;
   logic              w_hit;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_halt;

`ifdef SEQ_LSB_FIRST_EN
   assign w_serial_bit = r_shreg[0];
   assign w_shreg_next = r_shreg >> 1;
`else
   assign w_serial_bit = r_shreg[DATA_W-1];
   assign w_shreg_next = r_shreg << 1;
`endif

   // abort outranks start, and both outrank every normal-flow action.
   assign w_normal  = !i_abort && !i_start;
   assign w_accept  = (r_state == ARMED) && w_normal && i_in_valid;
   assign w_shift   = (r_state == SHIFT) && w_normal;
   assign w_hit     = w_shift && ({r_hist, w_serial_bit} == PATTERN) && (r_fill >= 3'd3);
   assign w_cnt_inc = (r_match_cnt == CNT_MAX) ? r_match_cnt : r_match_cnt + CNT_W'(1);
   assign w_halt    = w_hit && (i_threshold != '0) && (w_cnt_inc == i_threshold);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (i_abort) begin
         w_next_state = IDLE;
      end else if (i_start) begin
         w_next_state = ARMED;
      end else begin
         case (r_state)
            ARMED:   if (i_in_valid) w_next_state = SHIFT;
            SHIFT:   if (w_halt) w_next_state = HALT;
                     else if (r_bit_idx == LAST_IDX) w_next_state = ARMED;
            default: w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg     <= '0;
         r_bit_idx   <= '0;
         r_hist      <= '0;
         r_fill      <= '0;
         r_match     <= 1'b0;
         r_match_cnt <= '0;
      end else begin
         r_match <= w_hit;
         if (i_abort) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
         end else if (i_start) begin
            r_shreg     <= '0;
            r_bit_idx   <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_match_cnt <= '0;
         end else if (w_accept) begin
            r_shreg   <= i_in_data;
            r_bit_idx <= '0;
         end else if (w_shift) begin
            // History carries across words so a match may straddle a word boundary.
            r_shreg   <= w_shreg_next;
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            r_hist    <= {r_hist[1:0], w_serial_bit};
            r_fill    <= (r_fill == 3'd4) ? r_fill : r_fill + 3'd1;
            if (w_hit) r_match_cnt <= w_cnt_inc;
         end
      end
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      o_in_ready  = 1'b0;
      o_bit_out   = 1'b0;
      o_bit_vld   = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_match     = r_match;
      o_match_cnt = r_match_cnt;
      case (r_state)
         ARMED: begin
            o_busy     = 1'b1;
            o_in_ready = w_normal;
         end
         SHIFT: begin
            o_busy    = 1'b1;
            o_bit_vld = 1'b1;
            o_bit_out = w_serial_bit;
         end
         HALT:    o_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: directed and randomized stimulus for seq_stream_ctrl, checked every cycle
// against a queue-based behavioural model. Honours SEQ_LSB_FIRST_EN like the design.
`timescale 1ns/1ps
module tb_seq_stream_ctrl;

   localparam int DATA_W      = 8;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;
   localparam int PATTERN_VAL = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  thr;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              in_ready;
   logic              bit_out;
   logic              bit_vld;
   logic              match;
   logic [CNT_W-1:0]  match_cnt;
   logic              busy;
   logic              done;

   seq_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .PATTERN(4'b1001)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_abort     (abort),
      .i_threshold (thr),
      .i_in_data   (data),
      .i_in_valid  (valid),
      .o_in_ready  (in_ready),
      .o_bit_out   (bit_out),
      .o_bit_vld   (bit_vld),
      .o_match     (match),
      .o_match_cnt (match_cnt),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: bits still to emit, last three emitted bits, run status, count.
   bit m_running;
   bit m_halted;
   bit m_word[$];
   bit m_hist[$];
   int m_cnt;
   bit m_match;

   task automatic model_reset();
      m_running = 0;
      m_halted  = 0;
      m_word.delete();
      m_hist.delete();
      m_cnt     = 0;
      m_match   = 0;
   endtask

   task automatic model_step();
      bit nm;
      bit b;
      int code;
      nm = 0;
      if (abort) begin
         m_running = 0;
         m_halted  = 0;
         m_word.delete();
         m_hist.delete();
      end else if (start) begin
         m_running = 1;
         m_halted  = 0;
         m_word.delete();
         m_hist.delete();
         m_cnt     = 0;
      end else if (m_running && m_word.size() == 0) begin
         if (valid) begin
`ifdef SEQ_LSB_FIRST_EN
            for (int i = 0; i < DATA_W; i++) m_word.push_back(data[i]);
`else
            for (int i = DATA_W - 1; i >= 0; i--) m_word.push_back(data[i]);
`endif
         end
      end else if (m_running) begin
         b = m_word.pop_front();
         if (m_hist.size() == 3) begin
            code = int'(m_hist[0]) * 8 + int'(m_hist[1]) * 4 + int'(m_hist[2]) * 2 + int'(b);
            nm   = (code == PATTERN_VAL);
         end
         m_hist.push_back(b);
         if (m_hist.size() > 3) void'(m_hist.pop_front());
         if (nm) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (thr != 0 && m_cnt == int'(thr)) begin
               m_halted  = 1;
               m_running = 0;
               m_word.delete();
            end
         end
      end
      m_match = nm;
   endtask

   // Single compare process: outputs are checked mid-cycle, then the model advances
   // using the same inputs the DUT will sample at the next rising edge.
   always @(negedge clk) begin
      bit exp_vld;
      bit exp_bit;
      if (rst) begin
         check("rst_in_ready", in_ready, 0);
         check("rst_bit_vld", bit_vld, 0);
         check("rst_bit_out", bit_out, 0);
         check("rst_match", match, 0);
         check("rst_match_cnt", match_cnt, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         model_reset();
      end else begin
         exp_vld = (m_word.size() > 0);
         exp_bit = exp_vld ? m_word[0] : 1'b0;
         check("bit_vld", bit_vld, exp_vld);
         check("bit_out", bit_out, exp_bit);
         check("busy", busy, m_running);
         check("in_ready", in_ready, m_running && !exp_vld && !start && !abort);
         check("done", done, m_halted);
         check("match", match, m_match);
         check("match_cnt", match_cnt, m_cnt);
         model_step();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
   endtask

   // Maps a word written in serial arrival order to the word that must be presented.
   function automatic logic [DATA_W-1:0] ser(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] r;
`ifdef SEQ_LSB_FIRST_EN
      for (int i = 0; i < DATA_W; i++) r[i] = s[DATA_W-1-i];
`else
      r = s;
`endif
      return r;
   endfunction

   // Returns positioned in the first SHIFT cycle of the accepted word.
   task automatic send_word(input logic [DATA_W-1:0] w);
      bit ok;
      ok    = 0;
      data  = w;
      valid = 1;
      for (int i = 0; i < 64 && !ok; i++) begin
         #1;
         ok = in_ready;
         tick();
      end
      valid = 0;
      check("handshake_accept", ok, 1);
   endtask

   logic [DATA_W-1:0] rich [5] = '{8'h92, 8'h49, 8'h24, 8'h90, 8'h09};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; start = 0; abort = 0; valid = 0; data = '0; thr = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;

      // Idle without start ignores in_valid.
      valid = 1; data = 8'hff;
      repeat (4) tick();
      #1;
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
      valid = 0;

      // Single hit after the 4th bit, back to ARMED after the 8th.
      pulse_start();
      send_word(ser(8'b1001_0000));
      repeat (4) tick();
      #1;
      check("t2_match", match, 1);
      check("t2_cnt", match_cnt, 1);
      check("t2_model_cnt", m_cnt, 1);
      repeat (4) tick();
      #1;
      check("t2_rearmed_ready", in_ready, 1);
      check("t2_rearmed_vld", bit_vld, 0);

      // Overlapping hits.
      pulse_start();
      send_word(ser(8'b1001_0010));
      repeat (8) tick();
      #1;
      check("t3_cnt", match_cnt, 2);
      check("t3_model_cnt", m_cnt, 2);

      // Pattern straddling a word boundary.
      pulse_start();
      send_word(ser(8'h02));
      send_word(ser(8'h40));
      repeat (8) tick();
      #1;
      check("t4_cnt", match_cnt, 1);

      // Threshold halt discards the rest of the word.
      thr = 1;
      pulse_start();
      send_word(ser(8'b1001_0010));
      repeat (4) tick();
      #1;
      check("t5_done", done, 1);
      check("t5_vld", bit_vld, 0);
      check("t5_ready", in_ready, 0);
      check("t5_match", match, 1);
      check("t5_cnt", match_cnt, 1);
      repeat (3) tick();
      #1;
      check("t5_still_done", done, 1);
      check("t5_still_no_vld", bit_vld, 0);
      thr = 0;
      pulse_start();
      #1;
      check("t5_restart_cnt", match_cnt, 0);
      check("t5_restart_busy", busy, 1);
      check("t5_restart_done", done, 0);

      // Abort on the 3rd SHIFT cycle keeps the count.
      send_word(ser(8'h90));
      send_word(ser(8'hff));
      repeat (2) tick();
      #1;
      check("t6_vld_before_abort", bit_vld, 1);
      abort = 1;
      tick();
      abort = 0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_vld", bit_vld, 0);
      check("t6_ready", in_ready, 0);
      check("t6_cnt_held", match_cnt, 1);

      // Saturation: 260 hits into an 8-bit counter.
      pulse_start();
      for (int i = 0; i < 130; i++) send_word(ser(8'h92));
      repeat (9) tick();
      #1;
      check("sat_cnt", match_cnt, CNT_MAX);
      check("sat_model_cnt", m_cnt, CNT_MAX);

      // Threshold below the count never halts.
      thr = 5;
      send_word(ser(8'h92));
      repeat (9) tick();
      #1;
      check("low_thr_no_halt", done, 0);
      thr = 0;

      // Randomized traffic including one asynchronous reset mid-run.
      for (int c = 0; c < 6000; c++) begin
         start = ($urandom_range(0, 99) < 2);
         abort = ($urandom_range(0, 199) < 1);
         valid = ($urandom_range(0, 3) != 0);
         data  = ($urandom_range(0, 1) == 1) ? rich[$urandom_range(0, 4)] : DATA_W'($urandom);
         if ($urandom_range(0, 49) == 0) thr = CNT_W'($urandom_range(0, 6));
         if (c == 3000) begin
            #2;
            rst = 1;
            repeat (2) @(posedge clk);
            #1;
            rst = 0;
         end else begin
            tick();
         end
      end
      start = 0; abort = 0; valid = 0;
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
